// File: rtl/icache_dm_refill_if.sv
// Bus bundle between the instruction cache and its two neighbours: the fetch
// stage (request/ready handshake) and the memory side (line burst refill).
// The slave modport is the cache itself; the master modport is the
// environment, which plays both the fetch stage and the memory.
interface icache_dm_refill_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_busy;
    logic              cpu_ready;
    logic [WORD_W-1:0] cpu_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_valid;
    logic [WORD_W-1:0] mem_data;

    modport slave (
        input  cpu_req, cpu_addr, mem_gnt, mem_valid, mem_data,
        output cpu_busy, cpu_ready, cpu_data, mem_req, mem_addr
    );

    modport master (
        output cpu_req, cpu_addr, mem_gnt, mem_valid, mem_data,
        input  cpu_busy, cpu_ready, cpu_data, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_dm_refill.sv
// Direct-mapped instruction cache with an internal line-refill controller,
// whole-cache flush and wrapping hit/miss counters. Hits answer one cycle
// after acceptance; misses fetch the full line in order (word 0 first) and
// forward the requested word straight from the beat stream.
module icache_dm_refill #(
    parameter int ADDR_W = 32,
    parameter int LINES  = 64,
    parameter int WORDS  = 8,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    icache_dm_refill_if.slave  bus,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);
    localparam int WI_W  = $clog2(WORDS);
    localparam int OFF_W = WI_W + 2;
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam logic [WI_W-1:0] LAST_BEAT = WI_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state_r;
    state_t state_s;

    // Storage: data and tags are plain arrays (never reset), valid in flops.
    logic [WORDS*WORD_W-1:0] data_mem_r [LINES];
    logic [TAG_W-1:0]        tag_mem_r  [LINES];
    logic [LINES-1:0]        valid_r;

    logic [ADDR_W-1:2]  req_addr_r;
    logic [WI_W-1:0]    beat_r;
    logic               flush_pend_r;
    logic               cpu_ready_r;
    logic [WORD_W-1:0]  cpu_data_r;
    logic               mem_req_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [CNT_W-1:0]   hit_cnt_r;
    logic [CNT_W-1:0]   miss_cnt_r;

    logic [TAG_W-1:0]   cpu_tag_s;
    logic [IDX_W-1:0]   cpu_idx_s;
    logic [WI_W-1:0]    cpu_word_s;
    logic [TAG_W-1:0]   req_tag_s;
    logic [IDX_W-1:0]   req_idx_s;
    logic [WI_W-1:0]    req_word_s;
    logic               cpu_busy_s;
    logic               accept_s;
    logic               hit_s;
    logic [WORD_W-1:0]  rd_word_s;
    logic               last_beat_s;
    logic               unused_addr_s;

    // Address decode, hit lookup and acceptance for the incoming fetch.
    always_comb begin
        cpu_tag_s     = bus.cpu_addr[ADDR_W-1:IDX_W+OFF_W];
        cpu_idx_s     = bus.cpu_addr[IDX_W+OFF_W-1:OFF_W];
        cpu_word_s    = bus.cpu_addr[OFF_W-1:2];
        req_tag_s     = req_addr_r[ADDR_W-1:IDX_W+OFF_W];
        req_idx_s     = req_addr_r[IDX_W+OFF_W-1:OFF_W];
        req_word_s    = req_addr_r[OFF_W-1:2];
        // A pending flush keeps the cache busy for the one IDLE cycle that applies it.
        cpu_busy_s    = (state_r != IDLE) || flush || flush_pend_r;
        accept_s      = bus.cpu_req && !cpu_busy_s;
        hit_s         = valid_r[cpu_idx_s] && (tag_mem_r[cpu_idx_s] == cpu_tag_s);
        rd_word_s     = data_mem_r[cpu_idx_s][int'(cpu_word_s)*WORD_W +: WORD_W];
        last_beat_s   = bus.mem_valid && (beat_r == LAST_BEAT);
        unused_addr_s = &{1'b0, bus.cpu_addr[1:0]};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !hit_s) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    state_s = FILL;
                end else begin
                    state_s = REQ;
                end
            end
            FILL: begin
                if (last_beat_s) begin
                    state_s = RESP;
                end else begin
                    state_s = FILL;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control datapath: valid bits, flush bookkeeping, responses, refill request, counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r      <= '0;
            flush_pend_r <= 1'b0;
            req_addr_r   <= '0;
            beat_r       <= '0;
            cpu_ready_r  <= 1'b0;
            cpu_data_r   <= '0;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= '0;
            hit_cnt_r    <= '0;
            miss_cnt_r   <= '0;
        end else begin
            cpu_ready_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (flush || flush_pend_r) begin
                        valid_r      <= '0;
                        flush_pend_r <= 1'b0;
                    end else if (accept_s) begin
                        req_addr_r <= bus.cpu_addr[ADDR_W-1:2];
                        if (hit_s) begin
                            cpu_ready_r <= 1'b1;
                            cpu_data_r  <= rd_word_s;
                            hit_cnt_r   <= hit_cnt_r + CNT_W'(1);
                        end else begin
                            miss_cnt_r <= miss_cnt_r + CNT_W'(1);
                            mem_req_r  <= 1'b1;
                            mem_addr_r <= {bus.cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        mem_req_r <= 1'b0;
                        beat_r    <= '0;
                    end
                end
                FILL: begin
                    if (bus.mem_valid) begin
                        beat_r <= beat_r + WI_W'(1);
                        // Forward the requested word as it streams past.
                        if (beat_r == req_word_s) begin
                            cpu_data_r <= bus.mem_data;
                        end
                        if (beat_r == LAST_BEAT) begin
                            valid_r[req_idx_s] <= 1'b1;
                            cpu_ready_r        <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    cpu_ready_r <= 1'b0;
                end
                default: begin
                    cpu_ready_r <= 1'b0;
                end
            endcase
            // Flushes arriving while a refill is in flight wait until it has been answered.
            if ((state_r != IDLE) && flush) begin
                flush_pend_r <= 1'b1;
            end
        end
    end

    // Line storage writes during refill; suppressed in a reset cycle so an abandoned fill stops here.
    always_ff @(posedge clk) begin
        if (!rst && (state_r == FILL) && bus.mem_valid) begin
            data_mem_r[req_idx_s][int'(beat_r)*WORD_W +: WORD_W] <= bus.mem_data;
            if (beat_r == LAST_BEAT) begin
                tag_mem_r[req_idx_s] <= req_tag_s;
            end
        end
    end

    assign bus.cpu_busy  = cpu_busy_s;
    assign bus.cpu_ready = cpu_ready_r;
    assign bus.cpu_data  = cpu_data_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_addr  = mem_addr_r;
    assign hit_cnt       = hit_cnt_r;
    assign miss_cnt      = miss_cnt_r;
endmodule

// File: tb/tb_icache_dm_refill.sv
// Self-checking bench for icache_dm_refill at default geometry: a table of
// fetches with hand-computed results, then directed sequences for hit
// streaming, flush races and reset during a refill.
module tb_icache_dm_refill;
    localparam int WORDS = 8;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int total;
    int bad;

    icache_dm_refill_if #(.ADDR_W(32), .WORD_W(32)) bus ();

    icache_dm_refill #(
        .ADDR_W(32), .LINES(64), .WORDS(WORDS), .WORD_W(32), .CNT_W(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        int          gnt_dly;
        bit          gap;
        logic [31:0] exp_data;
        int          exp_lat;
        logic [31:0] exp_maddr;
        logic [31:0] exp_hits;
        logic [31:0] exp_miss;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents: line 0x1000 holds 0xA0.., every other line (addr^0x5A000000)+word.
    function automatic logic [31:0] mword(input logic [31:0] line, input int w);
        if (line == 32'h0000_1000) begin
            return 32'h0000_00A0 + 32'(w);
        end else begin
            return (line ^ 32'h5A00_0000) + 32'(w);
        end
    endfunction

    // One fetch, acting as memory too. Optional flush/reset injected on a given beat.
    task automatic fetch(input logic [31:0] a, input int gnt_dly, input bit gap,
                         input int flush_beat, input int rst_beat, input int max_cyc,
                         output logic [31:0] data, output int lat, output bit ok,
                         output bit saw_req, output logic [31:0] maddr, output bit busy_all);
        int          wait_cnt;
        bit          granted;
        int          b;
        bit          skip;
        int          g;
        logic [31:0] line;
        wait_cnt = 0; granted = 1'b0; b = 0; skip = 1'b0;
        ok = 1'b0; saw_req = 1'b0; maddr = 32'h0; busy_all = 1'b1; lat = 0; data = 32'h0;
        line = {a[31:5], 5'b00000};
        @(negedge clk);
        g = 0;
        while (bus.cpu_busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            if (bus.cpu_ready) begin
                ok = 1'b1; lat = cyc; data = bus.cpu_data;
                break;
            end
            if (!bus.cpu_busy) busy_all = 1'b0;
            bus.mem_gnt = 1'b0; bus.mem_valid = 1'b0; flush = 1'b0; rst = 1'b0;
            if (granted) begin
                if (b < WORDS) begin
                    if (gap && skip) begin
                        skip = 1'b0;
                    end else begin
                        bus.mem_valid = 1'b1;
                        bus.mem_data  = mword(line, b);
                        if (b == flush_beat) flush = 1'b1;
                        if (b == rst_beat) rst = 1'b1;
                        b++;
                        skip = gap;
                    end
                end
            end else if (bus.mem_req) begin
                if (!saw_req) begin
                    saw_req = 1'b1;
                    maddr   = bus.mem_addr;
                end
                if (wait_cnt == gnt_dly) begin
                    bus.mem_gnt = 1'b1;
                    granted     = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.mem_gnt = 1'b0; bus.mem_valid = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    logic [31:0] d;
    int          lat;
    bit          ok;
    bit          sreq;
    logic [31:0] ma;
    bit          busy_all;
    int          g;

    initial begin
        total = 0; bad = 0;
        //           addr          dly gap  data          lat maddr         hits miss
        vecs[0] = '{32'h0000_1004, 0, 1'b0, 32'h0000_00A1, 10, 32'h0000_1000, 32'd0, 32'd1};
        vecs[1] = '{32'h0000_1010, 0, 1'b0, 32'h0000_00A4,  1, 32'h0000_0000, 32'd1, 32'd1};
        vecs[2] = '{32'h0000_1804, 0, 1'b0, 32'h5A00_1801, 10, 32'h0000_1800, 32'd1, 32'd2};
        vecs[3] = '{32'h0000_1004, 0, 1'b0, 32'h0000_00A1, 10, 32'h0000_1000, 32'd1, 32'd3};
        vecs[4] = '{32'h0000_2028, 5, 1'b1, 32'h5A00_2022, 22, 32'h0000_2020, 32'd1, 32'd4};
        vecs[5] = '{32'h0000_202C, 0, 1'b0, 32'h5A00_2023,  1, 32'h0000_0000, 32'd2, 32'd4};
        vecs[6] = '{32'h0000_101C, 0, 1'b0, 32'h0000_00A7,  1, 32'h0000_0000, 32'd3, 32'd4};
        vecs[7] = '{32'h0000_1803, 0, 1'b0, 32'h5A00_1800, 10, 32'h0000_1800, 32'd3, 32'd5};

        rst = 1'b1; flush = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_addr = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_valid = 1'b0; bus.mem_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        chk("rst_cpu_ready", {31'h0, bus.cpu_ready}, 32'h0);
        chk("rst_cpu_data", bus.cpu_data, 32'h0);
        chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_hit_cnt", hit_cnt, 32'h0);
        chk("rst_miss_cnt", miss_cnt, 32'h0);
        chk("rst_cpu_busy", {31'h0, bus.cpu_busy}, 32'h0);

        // Table: cold miss, hits, conflict eviction, stalled refill.
        for (int i = 0; i < 8; i++) begin
            fetch(vecs[i].addr, vecs[i].gnt_dly, vecs[i].gap, -1, -1, 60, d, lat, ok, sreq, ma, busy_all);
            chk($sformatf("v%0d_ready", i), {31'h0, ok}, 32'h1);
            chk($sformatf("v%0d_data", i), d, vecs[i].exp_data);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_hit_cnt", i), hit_cnt, vecs[i].exp_hits);
            chk($sformatf("v%0d_miss_cnt", i), miss_cnt, vecs[i].exp_miss);
            if (vecs[i].exp_lat == 1) begin
                chk($sformatf("v%0d_no_mem_req", i), {31'h0, sreq}, 32'h0);
            end else begin
                chk($sformatf("v%0d_mem_req", i), {31'h0, sreq}, 32'h1);
                chk($sformatf("v%0d_mem_addr", i), ma, vecs[i].exp_maddr);
                chk($sformatf("v%0d_busy_held", i), {31'h0, busy_all}, 32'h1);
            end
        end

        // Hit streaming: refill line 0x1000, then 8 back-to-back hits.
        fetch(32'h0000_1000, 0, 1'b0, -1, -1, 60, d, lat, ok, sreq, ma, busy_all);
        chk("stream_fill_data", d, 32'h0000_00A0);
        @(negedge clk);
        g = 0;
        while (bus.cpu_busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                bus.cpu_req  = 1'b1;
                bus.cpu_addr = 32'h0000_1000 + 32'(4 * i);
            end else begin
                bus.cpu_req = 1'b0;
            end
            @(negedge clk);
            if (i < 8) begin
                chk($sformatf("stream%0d_ready", i), {31'h0, bus.cpu_ready}, 32'h1);
                chk($sformatf("stream%0d_data", i), bus.cpu_data, 32'h0000_00A0 + 32'(i));
                chk($sformatf("stream%0d_mem_req", i), {31'h0, bus.mem_req}, 32'h0);
            end
        end
        chk("stream_hit_cnt", hit_cnt, 32'd11);
        chk("stream_miss_cnt", miss_cnt, 32'd6);

        // Flush in IDLE with a request: busy, not accepted.
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_1000;
        flush        = 1'b1;
        #1;
        chk("flush_idle_busy", {31'h0, bus.cpu_busy}, 32'h1);
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        flush       = 1'b0;
        chk("flush_idle_no_ready", {31'h0, bus.cpu_ready}, 32'h0);
        chk("flush_idle_hit_cnt", hit_cnt, 32'd11);
        chk("flush_idle_miss_cnt", miss_cnt, 32'd6);
        chk("flush_idle_no_mem_req", {31'h0, bus.mem_req}, 32'h0);
        fetch(32'h0000_1000, 0, 1'b0, -1, -1, 60, d, lat, ok, sreq, ma, busy_all);
        chk("after_flush_latency", 32'(lat), 32'd10);
        chk("after_flush_data", d, 32'h0000_00A0);
        chk("after_flush_miss_cnt", miss_cnt, 32'd7);

        // Flush during FILL beat 3: response still delivered, then flush applied.
        fetch(32'h0000_1808, 0, 1'b0, 3, -1, 60, d, lat, ok, sreq, ma, busy_all);
        chk("flush_fill_ready", {31'h0, ok}, 32'h1);
        chk("flush_fill_data", d, 32'h5A00_1802);
        chk("flush_fill_latency", 32'(lat), 32'd10);
        @(posedge clk);
        #1;
        chk("flush_pend_busy", {31'h0, bus.cpu_busy}, 32'h1);
        chk("flush_pend_no_ready", {31'h0, bus.cpu_ready}, 32'h0);
        fetch(32'h0000_1808, 0, 1'b0, -1, -1, 60, d, lat, ok, sreq, ma, busy_all);
        chk("flush_fill_refetch_latency", 32'(lat), 32'd10);
        chk("flush_fill_refetch_miss_cnt", miss_cnt, 32'd9);
        chk("flush_fill_refetch_data", d, 32'h5A00_1802);

        // Reset during FILL beat 4, beats 5..7 still driven.
        fetch(32'h0000_2000, 0, 1'b0, -1, 4, 20, d, lat, ok, sreq, ma, busy_all);
        chk("rst_fill_no_ready", {31'h0, ok}, 32'h0);
        chk("rst_fill_hit_cnt", hit_cnt, 32'h0);
        chk("rst_fill_miss_cnt", miss_cnt, 32'h0);
        chk("rst_fill_mem_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_fill_busy", {31'h0, bus.cpu_busy}, 32'h0);
        fetch(32'h0000_2000, 0, 1'b0, -1, -1, 60, d, lat, ok, sreq, ma, busy_all);
        chk("rst_refetch_latency", 32'(lat), 32'd10);
        chk("rst_refetch_data", d, 32'h5A00_2000);
        chk("rst_refetch_miss_cnt", miss_cnt, 32'd1);
        chk("rst_refetch_mem_addr", ma, 32'h0000_2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icache_dm_refill.md
# icache_dm_refill

Parametrised direct-mapped instruction cache with an integrated line-refill controller, flush, and hit/miss statistics. It sits between the fetch stage (request/ready handshake) and the memory/bus interface (line-aligned burst refill, one word per beat). It is a successor to the fixed 64×256-bit line array: geometry is generic, misses are resolved internally, and the CPU never drives write data.

## Interface
- ADDR_W, 32: address width.
- LINES, 64: number of lines; power of 2, ≥2.
- WORDS, 8: words per line; power of 2, ≥2.
- WORD_W, 32: word width; the byte offset within a word is always 2 bits.
- CNT_W, 32: statistics counter width.
- Derived: OFF_W = log2(WORDS)+2, IDX_W = log2(LINES), TAG_W = ADDR_W−IDX_W−OFF_W. Address split: tag [ADDR_W-1:IDX_W+OFF_W], index [IDX_W+OFF_W-1:OFF_W], word [OFF_W-1:2].
- clk  in  1  rising-edge clock for all state.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  fetch request.
- cpu_addr  in  ADDR_W  fetch address; bits [1:0] ignored.
- cpu_busy  out  1  combinational: state≠IDLE, or flush=1.
- cpu_ready  out  1  one-cycle pulse; cpu_data valid.
- cpu_data  out  WORD_W  fetched word.
- flush  in  1  invalidate all lines.
- mem_req  out  1  refill request; held until mem_gnt.
- mem_addr  out  ADDR_W  line-aligned refill address (low OFF_W bits zero).
- mem_gnt  in  1  refill accepted.
- mem_valid  in  1  refill beat valid.
- mem_data  in  WORD_W  refill beat data.
- hit_cnt, miss_cnt  out  CNT_W  wrapping event counters.

## Operation
- Storage: data array LINES×WORDS×WORD_W; word w of a line occupies bits [w*WORD_W +: WORD_W]. Tag array LINES×TAG_W. Valid bit per line, in flops. No dirty bits.
- Request accepted when cpu_req=1 and cpu_busy=0. The accepted address is registered as req_addr.
- Hit: valid[idx] and tag[idx]==tag. The FSM stays in IDLE; next cycle cpu_ready=1 with the selected word; hit_cnt+1.
- Miss: miss_cnt+1, go to REQ.
- FSM states:
  - IDLE: accept requests.
  - REQ: mem_req=1, mem_addr = req_addr with the low OFF_W bits cleared. Go to FILL on mem_gnt.
  - FILL: beats arrive in order, words 0..WORDS-1; beat counter k; each mem_valid writes word k of the line at idx. On the last beat, write tag, set valid, go to RESP.
  - RESP: cpu_ready=1, cpu_data = requested word, forwarded from the fill (no array re-read hazard). Go to IDLE.
- mem_valid outside FILL is ignored. Beats may have gaps (mem_valid low).
- Flush in IDLE: cpu_busy=1 that cycle and the request is not accepted; all valid bits clear at the edge.
- Flush in REQ, FILL, or RESP: latched as pending. The refill completes and the response is delivered. Then one IDLE cycle with cpu_busy=1 applies the flush, which also invalidates the line just filled.
- Counters wrap at 2^CNT_W.

## Timing
- Reset (rst=1 at an edge), from any state:
  - state→IDLE; all valid=0; pending flush=0.
  - cpu_ready=0, cpu_data=0, mem_req=0, mem_addr=0, hit_cnt=0, miss_cnt=0.
  - A refill in progress is abandoned; later beats are ignored.
  - Tag and data arrays are not reset.
- Hit latency: 1 cycle (accept at edge N, cpu_ready during cycle N+1). Back-to-back hits sustain 1 request/cycle, since cpu_ready and the next acceptance coincide.
- Miss latency, accept to cpu_ready: 1 (REQ entry) + grant wait + WORDS beat cycles (with gaps extending this) + 1 (RESP). Minimum is WORDS+2 cycles at zero wait.
- mem_req rises the cycle after the miss is accepted. It deasserts the cycle after mem_gnt is sampled.
- A request in the same cycle as the final refill beat is not accepted (busy). The first acceptance is in the RESP→IDLE cycle.

## Test plan
- Cold miss, default parameters:
  - Stimulus: after rst, fetch 0x0000_1004 (idx 0, tag 2, word 1); mem_gnt immediate; beats 0xA0..0xA7.
  - Response: mem_addr=0x0000_1000; cpu_ready at cycle 10 with cpu_data=0xA1; miss_cnt=1.
- Hit streaming: fetch 0x1000, 0x1004 … 0x101C on consecutive cycles → 8 consecutive cpu_ready pulses, data 0xA0..0xA7; hit_cnt=8; mem_req stays 0.
- Conflict eviction: fetch 0x0000_1804 (idx 0, tag 3) → miss, refill at 0x1800. A re-fetch of 0x1004 then misses again; miss_cnt=3.
- Flush races:
  - Flush in IDLE with cpu_req=1: request not accepted that cycle.
  - Flush during FILL beat 3: the current response is still delivered; the next fetch to the same line misses.
- Reset mid-refill: rst during FILL beat 4, then beats 5..7 still driven → no cpu_ready, counters 0, mem_req 0. The next fetch misses.
- Stalls: mem_gnt delayed 5 cycles and beats gapped every other cycle → cpu_busy held throughout; correct word returned; latency = 1+5+15+1 cycles.
